// File: rtl/compression_dispatch_scheduler_pkg.sv
// Shared types, default sizing and width helpers for the compression
// dispatch scheduler and its credit counter.
package compress_sched_pkg;

    localparam int DEF_NUM_STREAM_ELEMENTS    = 4;
    localparam int DEF_MAX_UNCOMPRESSED_BYTES = 34;
    localparam int DEF_MAX_COMPRESSED_BYTES   = 34;
    localparam int DEF_FIFO_CAPACITY_BYTES    = 128;
    localparam int DEF_POP_BYTES_MAX          = 8;

    // Bits needed to hold a byte count from 0 up to max_bytes inclusive.
    function automatic int cnt_w(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    // Pointer width; a single element still needs one select bit.
    function automatic int idx_w(input int num_elems);
        return (num_elems > 1) ? $clog2(num_elems) : 1;
    endfunction

    // Credit width; the counter must be able to hold the full capacity.
    function automatic int cr_w(input int capacity);
        return $clog2(capacity + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CREDIT,
        ISSUE,
        WAIT_DONE
    } sched_state_t;

    localparam int DEF_CNT_W = cnt_w(DEF_MAX_UNCOMPRESSED_BYTES);

    // Byte count presented by one stream element at default sizing.
    typedef logic [DEF_CNT_W-1:0] byte_cnt_t;

endpackage

// File: rtl/compression_dispatch_scheduler_if.sv
// Bundle of stream-element, engine and return-FIFO signals seen by the
// dispatch scheduler. master = scheduler side, slave = environment side.
interface compression_dispatch_scheduler_if
    import compress_sched_pkg::*;
#(
    parameter int NUM_STREAM_ELEMENTS    = DEF_NUM_STREAM_ELEMENTS,
    parameter int MAX_UNCOMPRESSED_BYTES = DEF_MAX_UNCOMPRESSED_BYTES,
    parameter int FIFO_CAPACITY_BYTES    = DEF_FIFO_CAPACITY_BYTES,
    parameter int POP_BYTES_MAX          = DEF_POP_BYTES_MAX
);

    localparam int CNT_W = cnt_w(MAX_UNCOMPRESSED_BYTES);
    localparam int IDX_W = idx_w(NUM_STREAM_ELEMENTS);
    localparam int CR_W  = cr_w(FIFO_CAPACITY_BYTES);
    localparam int POP_W = cnt_w(POP_BYTES_MAX);

    // Stream elements
    logic [NUM_STREAM_ELEMENTS-1:0][CNT_W-1:0] use_byte_count;
    logic [NUM_STREAM_ELEMENTS-1:0]            use_last;
    logic [NUM_STREAM_ELEMENTS-1:0]            use_taken;
    logic [IDX_W-1:0]                          use_sel;

    // Compression engine
    logic                                      eng_start;
    logic                                      eng_busy;
    logic                                      eng_done;
    logic [CNT_W-1:0]                          eng_byte_count;

    // Return FIFO
    logic                                      fifo_pop;
    logic [POP_W-1:0]                          fifo_pop_bytes;

    // Status
    logic [CR_W-1:0]                           credit;
    logic                                      end_of_stream;
    logic                                      error;

    modport master (
        input  use_byte_count, use_last, eng_busy, eng_done, eng_byte_count,
               fifo_pop, fifo_pop_bytes,
        output use_taken, use_sel, eng_start, credit, end_of_stream, error
    );

    modport slave (
        output use_byte_count, use_last, eng_busy, eng_done, eng_byte_count,
               fifo_pop, fifo_pop_bytes,
        input  use_taken, use_sel, eng_start, credit, end_of_stream, error
    );

endinterface

// File: rtl/compression_dispatch_scheduler_fifo_credit_counter.sv
// Byte credit counter for the return FIFO: applies reserve, refund and pop
// in one cycle and saturates the result into [0, capacity].
module fifo_credit_counter
    import compress_sched_pkg::*;
#(
    parameter int FIFO_CAPACITY_BYTES = DEF_FIFO_CAPACITY_BYTES,
    parameter int CR_W                = cr_w(DEF_FIFO_CAPACITY_BYTES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CR_W-1:0] reserve,
    input  logic [CR_W-1:0] refund,
    input  logic [CR_W-1:0] pop_amount,
    output logic [CR_W-1:0] credit,
    output logic            overflow
);

    // One extra magnitude bit for the sum plus a sign bit for the subtract.
    localparam int SUM_W = CR_W + 2;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(FIFO_CAPACITY_BYTES);
    localparam logic [CR_W-1:0]         CAP   = CR_W'(FIFO_CAPACITY_BYTES);

    logic signed [SUM_W-1:0] sum;

    function automatic logic [CR_W-1:0] sat_credit(input logic signed [SUM_W-1:0] v);
        if (v > CAP_S) begin
            return CAP;
        end else if (v < 0) begin
            return '0;
        end else begin
            return v[CR_W-1:0];
        end
    endfunction

    function automatic logic out_of_range(input logic signed [SUM_W-1:0] v);
        return (v > CAP_S) || (v < 0);
    endfunction

    // Next-credit arithmetic and range flag for this cycle.
    always_comb begin
        sum      = $signed({2'b00, credit}) - $signed({2'b00, reserve})
                 + $signed({2'b00, refund}) + $signed({2'b00, pop_amount});
        overflow = out_of_range(sum);
    end

    // Credit register, full capacity after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= CAP;
        end else begin
            credit <= sat_credit(sum);
        end
    end

endmodule

// File: rtl/compression_dispatch_scheduler.sv
// Round-robin dispatcher feeding stream elements into the shared compression
// engine, one block in flight, gated by return-FIFO byte credit.
module compression_dispatch_scheduler
    import compress_sched_pkg::*;
#(
    parameter int NUM_STREAM_ELEMENTS    = DEF_NUM_STREAM_ELEMENTS,
    parameter int MAX_UNCOMPRESSED_BYTES = DEF_MAX_UNCOMPRESSED_BYTES,
    parameter int MAX_COMPRESSED_BYTES   = DEF_MAX_COMPRESSED_BYTES,
    parameter int FIFO_CAPACITY_BYTES    = DEF_FIFO_CAPACITY_BYTES,
    parameter int POP_BYTES_MAX          = DEF_POP_BYTES_MAX
) (
    input  logic                               dataIn_clk,
    input  logic                               dataIn_aresetn,
    compression_dispatch_scheduler_if.master   bus
);

    localparam int CNT_W = cnt_w(MAX_UNCOMPRESSED_BYTES);
    localparam int IDX_W = idx_w(NUM_STREAM_ELEMENTS);
    localparam int CR_W  = cr_w(FIFO_CAPACITY_BYTES);
    localparam int POP_W = cnt_w(POP_BYTES_MAX);

    localparam logic [CR_W-1:0]  RESERVE_AMT = CR_W'(MAX_COMPRESSED_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_STREAM_ELEMENTS - 1);

    sched_state_t                   state;
    logic [IDX_W-1:0]               ptr;
    logic [IDX_W-1:0]               sel;
    logic [NUM_STREAM_ELEMENTS-1:0] taken;
    logic                           start;
    logic                           eos;
    logic                           err;
    logic                           last_pending;

    logic [CR_W-1:0]                credit;
    logic                           credit_ovf;

    logic [CNT_W-1:0]               done_bytes;
    logic [POP_W-1:0]               pop_bytes;
    logic                           elem_ready;
    logic                           can_issue;
    logic                           done_valid;
    logic                           done_bad;
    logic                           done_spurious;
    logic [CR_W-1:0]                reserve_amt;
    logic [CR_W-1:0]                refund_amt;
    logic [CR_W-1:0]                pop_amt;

    assign done_bytes = bus.eng_byte_count;
    assign pop_bytes  = bus.fifo_pop_bytes;

    // Issue qualification and the three credit terms for this cycle.
    always_comb begin
        elem_ready    = (bus.use_byte_count[ptr] != '0);
        can_issue     = (credit >= RESERVE_AMT) && !bus.eng_busy;
        done_valid    = (state == WAIT_DONE) && bus.eng_done;
        done_bad      = done_valid && (int'(done_bytes) > MAX_COMPRESSED_BYTES);
        done_spurious = bus.eng_done && (state != WAIT_DONE);

        reserve_amt = (state == ISSUE) ? RESERVE_AMT : '0;
        refund_amt  = '0;
        if (done_valid && !done_bad) begin
            // Give back the part of the worst-case reservation the block did not use.
            refund_amt = CR_W'(MAX_COMPRESSED_BYTES - int'(done_bytes));
        end
        pop_amt = bus.fifo_pop ? CR_W'(pop_bytes) : '0;
    end

    fifo_credit_counter #(
        .FIFO_CAPACITY_BYTES (FIFO_CAPACITY_BYTES),
        .CR_W                (CR_W)
    ) u_credit (
        .clk        (dataIn_clk),
        .rst_n      (dataIn_aresetn),
        .reserve    (reserve_amt),
        .refund     (refund_amt),
        .pop_amount (pop_amt),
        .credit     (credit),
        .overflow   (credit_ovf)
    );

    // Dispatch FSM with registered grant, start, end-of-stream and error outputs.
    always_ff @(posedge dataIn_clk or negedge dataIn_aresetn) begin
        if (!dataIn_aresetn) begin
            state        <= IDLE;
            ptr          <= '0;
            sel          <= '0;
            taken        <= '0;
            start        <= 1'b0;
            eos          <= 1'b0;
            err          <= 1'b0;
            last_pending <= 1'b0;
        end else begin
            taken <= '0;
            start <= 1'b0;
            eos   <= 1'b0;
            if (credit_ovf || done_bad || done_spurious) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // The pointer waits on an empty element to keep stream order.
                    if (elem_ready) begin
                        state <= can_issue ? ISSUE : WAIT_CREDIT;
                    end
                end
                WAIT_CREDIT: begin
                    if (can_issue) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    taken        <= NUM_STREAM_ELEMENTS'(1) << ptr;
                    start        <= 1'b1;
                    last_pending <= bus.use_last[ptr];
                    ptr          <= (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
                    state        <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.eng_done) begin
                        if (last_pending) begin
                            eos          <= 1'b1;
                            last_pending <= 1'b0;
                        end
                        // The engine mux follows the pointer only once the block is finished.
                        sel   <= ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.use_taken     = taken;
    assign bus.use_sel       = sel;
    assign bus.eng_start     = start;
    assign bus.credit        = credit;
    assign bus.end_of_stream = eos;
    assign bus.error         = err;

endmodule
